// File: rtl/alu_sequencer.sv
// alu_sequencer: request/response front end for the 16-bit ALU.
// Takes an opcode plus two operands, drives the ALU operand/control lines for
// one cycle (or a 33-cycle shift-and-add sequence for MUL), captures the bus
// result and flags, and holds the response until the consumer accepts it.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// IDLE     | ready for a request; after acceptance, one decode cycle
// EXEC     | single ALU cycle for ops 0..17, result captured at its end
// MUL_ADD  | acc <= acc + mx when my[0]=1, else acc passed through
// MUL_DBL  | mx <= mx + mx, my >>= 1, cnt++
// MUL_FLAG | acc passed through the ALU once more to obtain the Z/LT flags
// RESP     | response held until rsp_ready
//
// Only WIDTH=16 is supported; the control words assume a 16-bit ALU.

module alu_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [4:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_z,
   output logic             rsp_lt,
   output logic             rsp_err,
   output logic [WIDTH-1:0] alu_x,
   output logic [WIDTH-1:0] alu_y,
   output logic [5:0]       alu_c,
   output logic             alu_en_bar,
   input  logic [WIDTH-1:0] alu_bus,
   input  logic             alu_z,
   input  logic             alu_lt
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      EXEC     = 3'd1,
      MUL_ADD  = 3'd2,
      MUL_DBL  = 3'd3,
      MUL_FLAG = 3'd4,
      RESP     = 3'd5
   } state_t;

   localparam logic [4:0] OP_MUL = 5'd18;
   localparam logic [5:0] C_ADD  = 6'd42;
   localparam logic [5:0] C_PASSX = 6'd34;
   localparam logic [4:0] MUL_LAST = 5'd15;

   state_t           state_q;
   logic             pend_q;
   logic [4:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;

   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] mx_q;
   logic [WIDTH-1:0] my_q;
   logic [4:0]       cnt_q;

   logic             req_ready_q;
   logic             rsp_valid_q;
   logic [WIDTH-1:0] rsp_data_q;
   logic             rsp_z_q;
   logic             rsp_lt_q;
   logic             rsp_err_q;
   logic [WIDTH-1:0] alu_x_q;
   logic [WIDTH-1:0] alu_y_q;
   logic [5:0]       alu_c_q;
   logic             alu_en_bar_q;

   // ALU control word for each single-cycle opcode.
   function automatic logic [5:0] ctrl_of(input logic [4:0] op);
      logic [5:0] c;
      case (op)
         5'd0:    c = 6'd42;
         5'd1:    c = 6'd59;
         5'd2:    c = 6'd47;
         5'd3:    c = 6'd40;
         5'd4:    c = 6'd61;
         5'd5:    c = 6'd2;
         5'd6:    c = 6'd23;
         5'd7:    c = 6'd20;
         5'd8:    c = 6'd34;
         5'd9:    c = 6'd10;
         5'd10:   c = 6'd50;
         5'd11:   c = 6'd14;
         5'd12:   c = 6'd39;
         5'd13:   c = 6'd27;
         5'd14:   c = 6'd55;
         5'd15:   c = 6'd31;
         5'd16:   c = 6'd38;
         5'd17:   c = 6'd26;
         default: c = 6'd0;
      endcase
      return c;
   endfunction

   // Sequencer FSM; every output is a register loaded for the state being entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         pend_q       <= 1'b0;
         op_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         acc_q        <= '0;
         mx_q         <= '0;
         my_q         <= '0;
         cnt_q        <= '0;
         req_ready_q  <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
         rsp_z_q      <= 1'b0;
         rsp_lt_q     <= 1'b0;
         rsp_err_q    <= 1'b0;
         alu_x_q      <= '0;
         alu_y_q      <= '0;
         alu_c_q      <= '0;
         alu_en_bar_q <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (!pend_q) begin
                  if (req_valid && req_ready_q) begin
                     op_q        <= req_op;
                     a_q         <= req_a;
                     b_q         <= req_b;
                     pend_q      <= 1'b1;
                     req_ready_q <= 1'b0;
                  end
               end else begin
                  // Decode cycle: the latched opcode selects the path.
                  pend_q <= 1'b0;
                  if (op_q == OP_MUL) begin
                     acc_q        <= '0;
                     mx_q         <= a_q;
                     my_q         <= b_q;
                     cnt_q        <= '0;
                     alu_x_q      <= '0;
                     alu_y_q      <= a_q;
                     alu_c_q      <= b_q[0] ? C_ADD : C_PASSX;
                     alu_en_bar_q <= 1'b0;
                     state_q      <= MUL_ADD;
                  end else if (op_q > OP_MUL) begin
                     rsp_data_q  <= '0;
                     rsp_z_q     <= 1'b1;
                     rsp_lt_q    <= 1'b0;
                     rsp_err_q   <= 1'b1;
                     rsp_valid_q <= 1'b1;
                     state_q     <= RESP;
                  end else begin
                     alu_x_q      <= a_q;
                     alu_y_q      <= b_q;
                     alu_c_q      <= ctrl_of(op_q);
                     alu_en_bar_q <= 1'b0;
                     state_q      <= EXEC;
                  end
               end
            end

            EXEC, MUL_FLAG: begin
               rsp_data_q   <= alu_bus;
               rsp_z_q      <= alu_z;
               rsp_lt_q     <= alu_lt;
               rsp_err_q    <= 1'b0;
               rsp_valid_q  <= 1'b1;
               alu_x_q      <= '0;
               alu_y_q      <= '0;
               alu_c_q      <= '0;
               alu_en_bar_q <= 1'b1;
               state_q      <= RESP;
            end

            MUL_ADD: begin
               acc_q   <= alu_bus;
               alu_x_q <= mx_q;
               alu_y_q <= mx_q;
               alu_c_q <= C_ADD;
               state_q <= MUL_DBL;
            end

            MUL_DBL: begin
               mx_q  <= alu_bus;
               my_q  <= my_q >> 1;
               cnt_q <= cnt_q + 5'd1;
               alu_x_q <= acc_q;
               if (cnt_q == MUL_LAST) begin
                  alu_y_q <= '0;
                  alu_c_q <= C_PASSX;
                  state_q <= MUL_FLAG;
               end else begin
                  // my[1] is the multiplier bit the next MUL_ADD will test.
                  alu_y_q <= alu_bus;
                  alu_c_q <= my_q[1] ? C_ADD : C_PASSX;
                  state_q <= MUL_ADD;
               end
            end

            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end
            end

            default: begin
               state_q      <= IDLE;
               pend_q       <= 1'b0;
               req_ready_q  <= 1'b1;
               rsp_valid_q  <= 1'b0;
               alu_en_bar_q <= 1'b1;
            end
         endcase
      end
   end

   assign req_ready  = req_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_z      = rsp_z_q;
   assign rsp_lt     = rsp_lt_q;
   assign rsp_err    = rsp_err_q;
   assign alu_x      = alu_x_q;
   assign alu_y      = alu_y_q;
   assign alu_c      = alu_c_q;
   assign alu_en_bar = alu_en_bar_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a behavioural ALU drives the shared bus, and
// results are compared with plain arithmetic on the requested operation.

module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [4:0]  req_op = '0;
   logic [15:0] req_a = '0;
   logic [15:0] req_b = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [15:0] rsp_data;
   logic        rsp_z;
   logic        rsp_lt;
   logic        rsp_err;
   logic [15:0] alu_x;
   logic [15:0] alu_y;
   logic [5:0]  alu_c;
   logic        alu_en_bar;
   wire  [15:0] alu_bus;
   logic        alu_z;
   logic        alu_lt;

   int tests = 0;
   int fails = 0;
   int en_cnt = 0;

   always #5 clk = ~clk;

   alu_sequencer #(.WIDTH(16)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_z(rsp_z), .rsp_lt(rsp_lt), .rsp_err(rsp_err),
      .alu_x(alu_x), .alu_y(alu_y), .alu_c(alu_c), .alu_en_bar(alu_en_bar),
      .alu_bus(alu_bus), .alu_z(alu_z), .alu_lt(alu_lt)
   );

   // Behavioural ALU: {ex,nx,ey,ny,f,no}, ex/ey=0 zero the operand.
   logic [15:0] ax, ay, af, aout;
   always_comb begin
      ax   = alu_c[5] ? alu_x : 16'h0000;
      ax   = alu_c[4] ? ~ax : ax;
      ay   = alu_c[3] ? alu_y : 16'h0000;
      ay   = alu_c[2] ? ~ay : ay;
      af   = alu_c[1] ? ax + ay : ax & ay;
      aout = alu_c[0] ? ~af : af;
   end
   assign alu_bus = alu_en_bar ? 16'hzzzz : aout;
   assign alu_z   = (aout == 16'h0000);
   assign alu_lt  = aout[15];

   // Counts edges at which the ALU was driving the bus.
   always @(posedge clk) if (alu_en_bar === 1'b0) en_cnt <= en_cnt + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: result of each opcode by plain arithmetic; bit 16 is the error flag.
   function automatic logic [16:0] model(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
      logic [15:0] r;
      logic [31:0] p;
      logic        e;
      e = 1'b0;
      p = 32'(a) * 32'(b);
      case (op)
         5'd0:  r = a + b;
         5'd1:  r = a - b;
         5'd2:  r = b - a;
         5'd3:  r = a & b;
         5'd4:  r = a | b;
         5'd5:  r = 16'd0;
         5'd6:  r = 16'd1;
         5'd7:  r = 16'hFFFF;
         5'd8:  r = a;
         5'd9:  r = b;
         5'd10: r = ~a;
         5'd11: r = ~b;
         5'd12: r = 16'd0 - a;
         5'd13: r = 16'd0 - b;
         5'd14: r = a + 16'd1;
         5'd15: r = b + 16'd1;
         5'd16: r = a - 16'd1;
         5'd17: r = b - 16'd1;
         5'd18: r = p[15:0];
         default: begin r = 16'd0; e = 1'b1; end
      endcase
      return {e, r};
   endfunction

   task automatic do_req(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b, input int hold);
      logic [16:0] m;
      int lat, exp_lat, exp_en, s0;
      bit got;
      m = model(op, a, b);
      exp_lat = (op < 5'd18) ? 2 : (op == 5'd18) ? 34 : 1;
      exp_en  = (op < 5'd18) ? 1 : (op == 5'd18) ? 33 : 0;
      check("req_ready_before", {31'd0, req_ready}, 32'd1);
      req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
      rsp_ready = (hold == 0);
      @(posedge clk); #1;
      req_valid = 1'b0; req_a = 16'hDEAD; req_b = 16'hBEEF; req_op = 5'd0;
      s0 = en_cnt;
      lat = 0; got = 0;
      while (!got && lat < 60) begin
         @(posedge clk); #1;
         lat++;
         if (rsp_valid === 1'b1) got = 1;
         else check("req_ready_busy", {31'd0, req_ready}, 32'd0);
      end
      if (!got) begin
         check("rsp_timeout", 32'(lat), 32'(exp_lat));
         return;
      end
      check("latency", 32'(lat), 32'(exp_lat));
      check("alu_cycles", 32'(en_cnt - s0), 32'(exp_en));
      check("rsp_data", {16'd0, rsp_data}, {16'd0, m[15:0]});
      check("rsp_z", {31'd0, rsp_z}, {31'd0, m[15:0] == 16'd0});
      check("rsp_lt", {31'd0, rsp_lt}, {31'd0, m[15]});
      check("rsp_err", {31'd0, rsp_err}, {31'd0, m[16]});
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("hold_valid", {31'd0, rsp_valid}, 32'd1);
         check("hold_data", {13'd0, rsp_err, rsp_lt, rsp_z, rsp_data},
               {13'd0, m[16], m[15], m[15:0] == 16'd0, m[15:0]});
         check("hold_ready", {30'd0, req_ready, alu_en_bar}, 32'd1);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("consumed", {30'd0, rsp_valid, req_ready}, 32'd1);
      rsp_ready = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_rsp", {11'd0, rsp_valid, rsp_z, rsp_lt, rsp_err, rsp_data}, 32'd0);
      check("rst_ctl", {24'd0, req_ready, alu_en_bar, alu_c}, {24'd0, 2'b11, 6'd0});
      check("rst_xy", {alu_x, alu_y}, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      do_req(5'd0,  16'h1234, 16'h0077, 0);
      do_req(5'd1,  16'd5,    16'd7,    0);
      do_req(5'd2,  16'd5,    16'd7,    0);
      do_req(5'd5,  16'h4321, 16'h8765, 0);
      do_req(5'd16, 16'd0,    16'd9,    0);
      do_req(5'd18, 16'd300,  16'd300,  0);
      do_req(5'd18, 16'hFFFF, 16'hFFFF, 0);
      do_req(5'd18, 16'd0,    16'h1234, 0);
      do_req(5'd4,  16'h00F0, 16'h0F00, 5);
      do_req(5'd25, 16'h1111, 16'h2222, 0);

      // Reset in the middle of a multiply drops the request.
      rsp_ready = 1'b0;
      req_op = 5'd18; req_a = 16'd77; req_b = 16'd99; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("midrst_valid", {31'd0, rsp_valid}, 32'd0);
      check("midrst_en_bar", {31'd0, alu_en_bar}, 32'd1);
      check("midrst_ready", {31'd0, req_ready}, 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
      do_req(5'd0, 16'd1, 16'd1, 0);

      for (int k = 0; k < 24; k++) begin
         logic [4:0] op;
         op = (k % 4 == 3) ? 5'd18 : 5'($urandom_range(0, 31));
         do_req(op, 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
